// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: start/config, UART byte stream and RAM write port of uart_mem_loader
interface uart_mem_loader_if #(
  parameter int WORD_WIDTH = 96,
  parameter int ADDR_WIDTH = 12
);
  logic                  startN;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [ADDR_WIDTH:0]   wordCount;
  logic [7:0]            rxData;
  logic                  rxValid;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WORD_WIDTH-1:0] memDataOut;
  logic                  memWrEn;
  logic                  busy;
  logic                  done;
  logic                  chkError;
  modport master (
    output startN, baseAddr, wordCount, rxData, rxValid,
    input  memAddr, memDataOut, memWrEn, busy, done, chkError
  );
  modport slave (
    input  startN, baseAddr, wordCount, rxData, rxValid,
    output memAddr, memDataOut, memWrEn, busy, done, chkError
  );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: assembles UART bytes MSB-first into RAM words written from a base address.
// Define UART_MEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load.
module uart_mem_loader #(
  parameter int WORD_WIDTH = 96,
  parameter int ADDR_WIDTH = 12
) (
  input  logic           clk,
  input  logic           rst,
  uart_mem_loader_if.slave bus
);
  localparam int BYTES_PER_WORD = (WORD_WIDTH + 7) / 8;
  localparam int BW = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  typedef enum logic [1:0] {
    IDLE,
    RECV,
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base, r_addr;
  logic [ADDR_WIDTH:0]   r_count, r_word_idx;
  logic [BW-1:0]         r_byte_cnt;
  logic [WORD_WIDTH-1:0] r_shift, r_data, w_shift;
  logic                  r_wr;
  logic                  w_start, w_take, w_word_end;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_chk;
  logic                  r_chk_err;
`endif
  assign w_start    = !bus.startN && (r_state == IDLE || r_state == DONE);
  // once every word has been assembled no further data byte is accepted
  assign w_take     = bus.rxValid && r_state == RECV && r_word_idx != r_count;
  assign w_word_end = w_take && r_byte_cnt == BW'(BYTES_PER_WORD - 1);
  // truncation drops the bits of byte 0 that do not fit the word
  assign w_shift    = WORD_WIDTH'({r_shift, bus.rxData});
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_start)
      w_next = bus.wordCount != '0 ? RECV : DONE;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    else if (w_word_end && r_word_idx + (ADDR_WIDTH+1)'(1) == r_count)
      w_next = CHECK;
    else if (r_state == CHECK && bus.rxValid)
      w_next = DONE;
    bus.busy     = r_state == RECV || r_state == CHECK;
    bus.chkError = r_chk_err;
`else
    else if (r_state == RECV && r_wr && r_word_idx == r_count)
      w_next = DONE;
    bus.busy     = r_state == RECV;
    bus.chkError = 1'b0;
`endif
    bus.done       = r_state == DONE;
    bus.memWrEn    = r_wr;
    bus.memAddr    = r_addr;
    bus.memDataOut = r_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_base     <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      r_chk      <= '0;
      r_chk_err  <= 1'b0;
`endif
    end else begin
      r_wr <= w_word_end;
      if (w_start) begin
        r_base     <= bus.baseAddr;
        r_count    <= bus.wordCount;
        r_word_idx <= '0;
        r_byte_cnt <= '0;
        r_shift    <= '0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        r_chk      <= '0;
        r_chk_err  <= 1'b0;
`endif
      end
      if (w_take) begin
        r_shift    <= w_shift;
        r_byte_cnt <= w_word_end ? '0 : r_byte_cnt + BW'(1);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        r_chk      <= r_chk ^ bus.rxData;
`endif
      end
      if (w_word_end) begin
        r_data     <= w_shift;
        r_addr     <= r_base + r_word_idx[ADDR_WIDTH-1:0];
        r_word_idx <= r_word_idx + (ADDR_WIDTH+1)'(1);
      end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      if (r_state == CHECK && bus.rxValid)
        r_chk_err <= bus.rxData != r_chk;
`endif
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: scoreboard bench for uart_mem_loader (24-bit words, plus a 12-bit truncation instance)
module tb_uart_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n_wr = 0;
  typedef struct packed {
    logic [11:0] a;
    logic [23:0] d;
  } exp_t;
  exp_t q[$];
  uart_mem_loader_if #(.WORD_WIDTH(24), .ADDR_WIDTH(12)) bus();
  uart_mem_loader_if #(.WORD_WIDTH(12), .ADDR_WIDTH(12)) bus2();
  uart_mem_loader #(.WORD_WIDTH(24), .ADDR_WIDTH(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  uart_mem_loader #(.WORD_WIDTH(12), .ADDR_WIDTH(12)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.memWrEn === 1'b1) begin
      n_wr++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h expected no write", bus.memAddr, bus.memDataOut);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.memAddr !== e.a || bus.memDataOut !== e.d) begin
          bad++;
          $display("FAIL write addr=%h data=%h expected addr=%h data=%h", bus.memAddr, bus.memDataOut, e.a, e.d);
        end
      end
    end
  task automatic start_load(input logic [11:0] base, input logic [12:0] cnt);
    @(negedge clk);
    bus.baseAddr = base;
    bus.wordCount = cnt;
    bus.startN = 1'b0;
    @(negedge clk);
    bus.startN = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rxData = b;
    bus.rxValid = 1'b1;
    @(negedge clk);
    bus.rxValid = 1'b0;
  endtask
  task automatic end_load(input logic [7:0] ck);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    send_byte(ck);
`else
    if (ck === 8'hxx) $display("unused checksum");
`endif
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.memAddr, bus.memDataOut, bus.memWrEn, bus.busy, bus.done, bus.chkError} !== '0) begin
      bad++;
      $display("FAIL reset_outputs addr=%h data=%h wr=%b busy=%b done=%b chk=%b expected all 0",
               bus.memAddr, bus.memDataOut, bus.memWrEn, bus.busy, bus.done, bus.chkError);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_two_words;
    logic [7:0] b[6] = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] x = 8'h00;
    int w0 = n_wr;
    q.push_back('{12'h010, 24'h123456});
    q.push_back('{12'h011, 24'hABCDEF});
    start_load(12'h010, 13'd2);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_recv busy=%b expected 1", bus.busy);
    end
    for (int i = 0; i < 6; i++) begin
      x ^= b[i];
      send_byte(b[i]);
      if (i < 5) repeat (3) @(negedge clk);
    end
`ifndef UART_MEM_LOADER_CHECKSUM_EN
    total++;
    if (bus.memWrEn !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL last_write_cycle wr=%b done=%b expected wr=1 done=0", bus.memWrEn, bus.done);
    end
`endif
    end_load(x);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.memWrEn !== 1'b0 || bus.chkError !== 1'b0) begin
      bad++;
      $display("FAIL two_words_done done=%b busy=%b wr=%b chk=%b expected 1 0 0 0", bus.done, bus.busy, bus.memWrEn, bus.chkError);
    end
    total++;
    if (n_wr - w0 != 2 || q.size() != 0) begin
      bad++;
      $display("FAIL two_words_count writes=%0d pending=%0d expected 2 0", n_wr - w0, q.size());
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] b[6];
    logic [7:0] x = 8'h00;
    int w0 = n_wr;
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      x ^= b[i];
    end
    q.push_back('{12'h100, {b[0], b[1], b[2]}});
    q.push_back('{12'h101, {b[3], b[4], b[5]}});
    start_load(12'h100, 13'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rxData = b[i];
      bus.rxValid = 1'b1;
    end
    @(negedge clk);
    bus.rxValid = 1'b0;
    end_load(x);
    total++;
    if (n_wr - w0 != 2 || q.size() != 0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back writes=%0d pending=%0d done=%b expected 2 0 1", n_wr - w0, q.size(), bus.done);
    end
  endtask
  task automatic test_zero_length;
    int w0;
    test_reset;
    w0 = n_wr;
    start_load(12'h055, 13'd0);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || n_wr != w0) begin
      bad++;
      $display("FAIL zero_length done=%b busy=%b writes=%0d expected 1 0 0", bus.done, bus.busy, n_wr - w0);
    end
    send_byte(8'h77);
    repeat (2) @(negedge clk);
    total++;
    if (n_wr != w0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL rx_in_done writes=%0d done=%b expected 0 1", n_wr - w0, bus.done);
    end
  endtask
  task automatic test_addr_wrap;
    logic [7:0] b[6];
    logic [7:0] x = 8'h00;
    int w0 = n_wr;
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      x ^= b[i];
    end
    q.push_back('{12'hFFF, {b[0], b[1], b[2]}});
    q.push_back('{12'h000, {b[3], b[4], b[5]}});
    start_load(12'hFFF, 13'd2);
    for (int i = 0; i < 6; i++) begin
      send_byte(b[i]);
      if (i == 1) start_load(12'h222, 13'd5);
    end
    end_load(x);
    total++;
    if (n_wr - w0 != 2 || q.size() != 0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL addr_wrap writes=%0d pending=%0d done=%b expected 2 0 1", n_wr - w0, q.size(), bus.done);
    end
  endtask
  task automatic test_reset_mid_word;
    int w0 = n_wr;
    start_load(12'h020, 13'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.memAddr, bus.memDataOut, bus.memWrEn, bus.busy, bus.done, bus.chkError} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs addr=%h data=%h wr=%b busy=%b done=%b chk=%b expected all 0",
               bus.memAddr, bus.memDataOut, bus.memWrEn, bus.busy, bus.done, bus.chkError);
    end
    @(negedge clk);
    rst = 1'b0;
    q.push_back('{12'h030, 24'h4B1D2E});
    start_load(12'h030, 13'd1);
    send_byte(8'h4B);
    send_byte(8'h1D);
    send_byte(8'h2E);
    end_load(8'h4B ^ 8'h1D ^ 8'h2E);
    total++;
    if (n_wr - w0 != 1 || q.size() != 0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_word writes=%0d pending=%0d done=%b expected 1 0 1", n_wr - w0, q.size(), bus.done);
    end
  endtask
  task automatic test_truncate;
    @(negedge clk);
    bus2.baseAddr = 12'h005;
    bus2.wordCount = 13'd1;
    bus2.startN = 1'b0;
    @(negedge clk);
    bus2.startN = 1'b1;
    bus2.rxData = 8'hAB;
    bus2.rxValid = 1'b1;
    @(negedge clk);
    bus2.rxData = 8'hCD;
    @(negedge clk);
    bus2.rxValid = 1'b0;
    total++;
    if (bus2.memWrEn !== 1'b1 || bus2.memDataOut !== 12'hBCD || bus2.memAddr !== 12'h005) begin
      bad++;
      $display("FAIL truncate wr=%b data=%h addr=%h expected 1 bcd 005", bus2.memWrEn, bus2.memDataOut, bus2.memAddr);
    end
    @(negedge clk);
    total++;
    if (bus2.memWrEn !== 1'b0 || bus2.memDataOut !== 12'hBCD || bus2.memAddr !== 12'h005) begin
      bad++;
      $display("FAIL output_hold wr=%b data=%h addr=%h expected 0 bcd 005", bus2.memWrEn, bus2.memDataOut, bus2.memAddr);
    end
  endtask
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] b[6] = '{8'h0F, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] x;
    for (int k = 0; k < 2; k++) begin
      int w0 = n_wr;
      x = 8'h00;
      for (int i = 0; i < 6; i++) x ^= b[i];
      q.push_back('{12'h040, {b[0], b[1], b[2]}});
      q.push_back('{12'h041, {b[3], b[4], b[5]}});
      start_load(12'h040, 13'd2);
      total++;
      if (bus.chkError !== 1'b0) begin
        bad++;
        $display("FAIL chk_cleared_on_start chk=%b expected 0", bus.chkError);
      end
      for (int i = 0; i < 6; i++) send_byte(b[i]);
      repeat (2) @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL check_state busy=%b done=%b expected 1 0", bus.busy, bus.done);
      end
      end_load(k == 0 ? x : ~x);
      total++;
      if (bus.done !== 1'b1 || bus.chkError !== (k == 1) || n_wr - w0 != 2 || q.size() != 0) begin
        bad++;
        $display("FAIL checksum_%0d done=%b chk=%b writes=%0d expected 1 %0d 2", k, bus.done, bus.chkError, n_wr - w0, k);
      end
    end
  endtask
`endif
  initial begin
    bus.startN = 1'b1;
    bus.baseAddr = '0;
    bus.wordCount = '0;
    bus.rxData = '0;
    bus.rxValid = 1'b0;
    bus2.startN = 1'b1;
    bus2.baseAddr = '0;
    bus2.wordCount = '0;
    bus2.rxData = '0;
    bus2.rxValid = 1'b0;
    test_reset;
    send_byte(8'h99);
    test_two_words;
    test_back_to_back;
    test_zero_length;
    test_addr_wrap;
    test_reset_mid_word;
    test_truncate;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
